// File: rtl/uart_image_loader.sv
// UART image loader: parses sync/header bytes and unpacks
// 1-bit pixels into the pixel RAM, then holds the frame.
module uart_image_loader #(
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic [7:0]        img_width,
  output logic [7:0]        img_height,
  output logic              frame_valid,
  input  logic              enc_done,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_PIX = 17'd1 << ADDR_W;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_W, S_HDR_H, S_PIX_WAIT, S_UNPACK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_q;
  logic [7:0]        w_q, w_d, h_q, h_d;
  logic [15:0]       npix_q, npix_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bit_q, bit_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              fv_q, fv_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              byte_ev;
  logic              counting;
  logic              timeout;
  logic [15:0]       prod;
  logic [15:0]       idx_inc;

  assign byte_ev  = rx_ready & ~rdy_q;
  assign prod     = 16'(w_q) * 16'(rx_data);
  assign idx_inc  = idx_q + 16'd1;
  assign counting = (state_q == S_HDR_W) ||
                    (state_q == S_HDR_H) ||
                    (state_q == S_PIX_WAIT);
  assign timeout  = counting && !byte_ev && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    npix_d    = npix_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    if (byte_ev || timeout) begin
      cnt_d = '0;
    end else if (counting) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (byte_ev && rx_data == SYNC_BYTE) begin
          state_d = S_HDR_W;
          err_d   = 1'b0;
        end
      end
      S_HDR_W: begin
        if (byte_ev) begin
          w_d     = rx_data;
          state_d = S_HDR_H;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HDR_H: begin
        if (byte_ev) begin
          h_d    = rx_data;
          npix_d = prod;
          if (w_q == 8'd0 || rx_data == 8'd0 ||
              {1'b0, prod} > MAX_PIX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = '0;
            state_d = S_PIX_WAIT;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PIX_WAIT: begin
        if (byte_ev) begin
          sh_d    = rx_data;
          bit_d   = '0;
          state_d = S_UNPACK;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_UNPACK: begin
        // a new byte while still unpacking means the stream outran us
        if (byte_ev) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = sh_q[7];
          sh_d      = {sh_q[6:0], 1'b0};
          idx_d     = idx_inc;
          bit_d     = bit_q + 3'd1;
          if (idx_inc == npix_q) begin
            state_d = S_DONE;
          end else if (bit_q == 3'd7) begin
            state_d = S_PIX_WAIT;
          end
        end
      end
      S_DONE: begin
        if (enc_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    fv_d   = (state_q == S_DONE) && !enc_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      npix_q    <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
      fv_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rx_ready;
      w_q       <= w_d;
      h_q       <= h_d;
      npix_q    <= npix_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fv_q      <= fv_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign img_width   = w_q;
  assign img_height  = h_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule
